// File: rtl/cpu_clock_controller.sv
// CPU clock-enable sequencer: free run at a programmable divided rate, halt,
// debounced single-step and CPU-requested wait released by a user resume.
//
// state | meaning
// ------+-------------------------------------------------------------
// HALT  | no ticks; run_sw starts RUN, a debounced step press enters STEP
// RUN   | counter advances, one cpu_tick every D cycles
// STEP  | exactly one cpu_tick this cycle, then back to HALT
// WAIT  | CPU asked to stop; a user resume leaves once halt_req is low
module cpu_clock_controller #(
    parameter int DIV_WIDTH       = 28,
    parameter int DEFAULT_DIV     = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 run_sw,
    input  logic                 step_btn,
    input  logic                 halt_req,
    input  logic                 resume,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    output logic                 cpu_tick,
    output logic                 clock_out,
    output logic [1:0]           state,
    output logic [31:0]          tick_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        WAIT = 2'b11
    } state_t;

    state_t               st_q;
    logic [DIV_WIDTH-1:0] divisor;
    logic [DIV_WIDTH-1:0] counter;
    logic [DIV_WIDTH-1:0] div_eff;
    logic                 sync_1;
    logic                 sync_2;
    logic [DB_W-1:0]      db_cnt;
    logic                 db_level;
    logic                 db_level_d;
    logic                 wrap;
    logic                 step_event;
    logic                 tick_next;

    assign state = st_q;

    // Divisors 0 and 1 both mean "tick every cycle".
    always_comb begin
        div_eff    = (divisor > DIV_WIDTH'(1)) ? divisor : DIV_WIDTH'(1);
        wrap       = (counter == div_eff - DIV_WIDTH'(1));
        step_event = db_level & ~db_level_d;
        tick_next  = 1'b0;
        if (st_q == RUN && !halt_req && run_sw && !div_load && wrap)
            tick_next = 1'b1;
        if (st_q == HALT && !(run_sw && !halt_req) && step_event)
            tick_next = 1'b1;
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            st_q       <= HALT;
            cpu_tick   <= 1'b0;
            clock_out  <= 1'b0;
            tick_count <= '0;
            counter    <= '0;
            divisor    <= DIV_WIDTH'(DEFAULT_DIV);
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            db_cnt     <= '0;
            db_level   <= 1'b0;
            db_level_d <= 1'b0;
        end else begin
            sync_1     <= step_btn;
            sync_2     <= sync_1;
            db_level_d <= db_level;

            if (!sync_2) begin
                db_cnt   <= '0;
                db_level <= 1'b0;
            end else if (!db_level) begin
                if (db_cnt == DB_LAST) db_level <= 1'b1;
                else                   db_cnt   <= db_cnt + DB_W'(1);
            end

            cpu_tick <= tick_next;
            if (tick_next) begin
                clock_out  <= ~clock_out;
                tick_count <= tick_count + 32'd1;
            end

            case (st_q)
                HALT: begin
                    counter <= '0;
                    if (run_sw && !halt_req) st_q <= RUN;
                    else if (step_event)     st_q <= STEP;
                end
                RUN: begin
                    if (halt_req) begin
                        st_q    <= WAIT;
                        counter <= '0;
                    end else if (!run_sw) begin
                        st_q    <= HALT;
                        counter <= '0;
                    end else if (wrap) begin
                        counter <= '0;
                    end else begin
                        counter <= counter + DIV_WIDTH'(1);
                    end
                end
                STEP: begin
                    st_q    <= HALT;
                    counter <= '0;
                end
                WAIT: begin
                    counter <= '0;
                    if (resume && !halt_req) st_q <= run_sw ? RUN : HALT;
                end
            endcase

            // A divisor load restarts the period; tick_next already excludes it.
            if (div_load) begin
                divisor <= div_value;
                counter <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed bench for cpu_clock_controller with an expected-value queue.
module tb_cpu_clock_controller;

    localparam logic [1:0] S_HALT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_WAIT = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_sw;
    logic        step_btn;
    logic        halt_req;
    logic        resume;
    logic        div_load;
    logic [27:0] div_value;
    logic        cpu_tick;
    logic        clock_out;
    logic [1:0]  state;
    logic [31:0] tick_count;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic        tk;
        logic        ck;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 0;
    logic        exp_clk = 1'b0;
    int          rc = 0;
    int          dexp = 3;

    cpu_clock_controller dut (
        .clock_in   (clk),
        .reset      (reset),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .halt_req   (halt_req),
        .resume     (resume),
        .div_load   (div_load),
        .div_value  (div_value),
        .cpu_tick   (cpu_tick),
        .clock_out  (clock_out),
        .state      (state),
        .tick_count (tick_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: push what this cycle must show, advance, pop and compare.
    task automatic cyc(input string tag, input logic [1:0] st, input logic tk);
        exp_t e;
        if (tk) begin
            exp_cnt = exp_cnt + 32'd1;
            exp_clk = ~exp_clk;
        end
        e.tag = tag; e.st = st; e.tk = tk; e.ck = exp_clk; e.cnt = exp_cnt;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        check({e.tag, ".state"}, 32'(state), 32'(e.st));
        check({e.tag, ".tick"},  32'(cpu_tick), 32'(e.tk));
        check({e.tag, ".clk"},   32'(clock_out), 32'(e.ck));
        check({e.tag, ".count"}, tick_count, e.cnt);
    endtask

    // RUN cycles following an entry/clear cycle; tick every dexp cycles.
    task automatic run_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            rc++;
            cyc(tag, S_RUN, (rc % dexp) == 0);
        end
    endtask

    // Button press from HALT; exact debounce latency is not assumed, only
    // that any tick comes with a single STEP cycle followed by HALT.
    task automatic press(input string tag, input int n_high, input int n_after, input int exp_ticks);
        exp_t e;
        int   ticks = 0;
        int   steps = 0;
        logic prev_step = 1'b0;
        exp_cnt = exp_cnt + 32'(exp_ticks);
        if (exp_ticks % 2 == 1) exp_clk = ~exp_clk;
        e.tag = tag; e.st = S_HALT; e.tk = 1'b0; e.ck = exp_clk; e.cnt = exp_cnt;
        sb.push_back(e);
        for (int i = 0; i < n_high + n_after; i++) begin
            step_btn = (i < n_high);
            @(posedge clk); #1;
            if (cpu_tick) ticks++;
            if (prev_step) check({tag, ".after_step"}, 32'(state), 32'(S_HALT));
            if (state == S_STEP) begin
                steps++;
                check({tag, ".step_tick"}, 32'(cpu_tick), 32'd1);
            end
            prev_step = (state == S_STEP);
        end
        step_btn = 1'b0;
        e = sb.pop_front();
        check({e.tag, ".ticks"}, 32'(ticks), 32'(exp_ticks));
        check({e.tag, ".steps"}, 32'(steps), 32'(exp_ticks));
        check({e.tag, ".state"}, 32'(state), 32'(e.st));
        check({e.tag, ".clk"},   32'(clock_out), 32'(e.ck));
        check({e.tag, ".count"}, tick_count, e.cnt);
    endtask

    initial begin
        reset = 1'b1; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
        resume = 1'b0; div_load = 1'b0; div_value = '0;
        @(posedge clk); #1;
        cyc("reset", S_HALT, 1'b0);

        // 1: free run at the default divisor of 3
        reset = 1'b0; run_sw = 1'b1;
        cyc("run_entry", S_RUN, 1'b0); rc = 0; dexp = 3;
        run_cycles("run_d3", 12);

        // 2: load one cycle before a tick suppresses it, then D=5, then D=1
        run_cycles("run_pre_load", 2);
        div_load = 1'b1; div_value = 28'd5;
        cyc("load5", S_RUN, 1'b0);
        div_load = 1'b0; dexp = 5; rc = 0;
        run_cycles("run_d5", 5);
        div_load = 1'b1; div_value = 28'd0;
        cyc("load0", S_RUN, 1'b0);
        div_load = 1'b0; dexp = 1; rc = 0;
        run_cycles("run_d1", 6);
        run_sw = 1'b0;
        cyc("to_halt", S_HALT, 1'b0);

        // 3: debounced single step
        press("glitch", 2, 10, 0);
        press("step1", 20, 10, 1);
        press("step2", 20, 10, 1);

        // 4: CPU wait and resume
        div_load = 1'b1; div_value = 28'd4;
        cyc("load4", S_HALT, 1'b0);
        div_load = 1'b0; dexp = 4;
        run_sw = 1'b1;
        cyc("run4_entry", S_RUN, 1'b0); rc = 0;
        run_cycles("run_d4", 5);
        halt_req = 1'b1;
        cyc("wait_entry", S_WAIT, 1'b0);
        for (int i = 0; i < 50; i++) cyc("wait_hold", S_WAIT, 1'b0);
        resume = 1'b1;
        cyc("resume_ignored", S_WAIT, 1'b0);
        resume = 1'b0;
        cyc("resume_not_kept", S_WAIT, 1'b0);
        halt_req = 1'b0;
        cyc("wait_released", S_WAIT, 1'b0);
        resume = 1'b1;
        cyc("resume_run", S_RUN, 1'b0); rc = 0;
        resume = 1'b0;
        run_cycles("run_after_wait", 4);
        halt_req = 1'b1;
        cyc("wait2_entry", S_WAIT, 1'b0);
        run_sw = 1'b0;
        cyc("wait2_sw_off", S_WAIT, 1'b0);
        halt_req = 1'b0;
        cyc("wait2_released", S_WAIT, 1'b0);
        resume = 1'b1;
        cyc("resume_halt", S_HALT, 1'b0);
        resume = 1'b0;
        cyc("halt_stay", S_HALT, 1'b0);

        // 5: reset mid-run with counter=2 and clock_out=1
        run_sw = 1'b1;
        cyc("run5_entry", S_RUN, 1'b0); rc = 0;
        run_cycles("run5", 4);
        if (!exp_clk) run_cycles("run5_phase", 4);
        run_cycles("run5_cnt2", 2);
        check("pre_reset.clk", 32'(clock_out), 32'd1);
        reset = 1'b1; run_sw = 1'b0;
        exp_cnt = 0; exp_clk = 1'b0;
        cyc("mid_reset", S_HALT, 1'b0);
        reset = 1'b0;
        press("step_after_reset", 20, 10, 1);
        run_sw = 1'b1;
        cyc("run6_entry", S_RUN, 1'b0); rc = 0; dexp = 3;
        run_cycles("run_default_div", 6);

        // 6: step presses ignored in RUN and WAIT; run_sw drop before a tick
        step_btn = 1'b1;
        run_cycles("run_btn", 12);
        step_btn = 1'b0;
        run_cycles("run_btn_rel", 6);
        halt_req = 1'b1;
        cyc("wait3_entry", S_WAIT, 1'b0);
        step_btn = 1'b1;
        for (int i = 0; i < 12; i++) cyc("wait_btn", S_WAIT, 1'b0);
        step_btn = 1'b0;
        for (int i = 0; i < 6; i++) cyc("wait_btn_rel", S_WAIT, 1'b0);
        halt_req = 1'b0;
        cyc("wait3_released", S_WAIT, 1'b0);
        resume = 1'b1;
        cyc("resume_run3", S_RUN, 1'b0); rc = 0;
        resume = 1'b0;
        run_cycles("run_pre_drop", 2);
        run_sw = 1'b0;
        cyc("drop_before_tick", S_HALT, 1'b0);
        for (int i = 0; i < 4; i++) cyc("halt_final", S_HALT, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
